pzcorebus_csr_responder: RTL and testbench

PZCOREBUS_CSR_RESPONDER -- requirements
Module: pzcorebus_csr_responder

---
 rtl/pzcorebus_csr_responder.sv | 130 +++++++++++++
 tb/tb_pzcorebus_csr_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_csr_responder.sv
// pzcorebus_csr_responder
//   Single-beat CSR target on a pzcorebus-style command/response interface.
//   Holds DEPTH registers of DATA_WIDTH bits. Posted writes complete in IDLE and
//   may be accepted every cycle. Reads and non-posted commands move the FSM to
//   RESP, where one response is held until the master accepts it.
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_mcmd_valid / o_scmd_accept    command handshake
//   i_mcmd, i_mid, i_maddr,
//   i_mdata, i_mbyte_enable         command payload
//   o_sresp_valid / i_mresp_accept  response handshake
//   o_sresp, o_sid, o_serror,
//   o_sdata, o_sresp_last           response payload (registered)
module pzcorebus_csr_responder #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mcmd_valid,
  output logic                      o_scmd_accept,
  input  logic [3:0]                i_mcmd,
  input  logic [ID_WIDTH-1:0]       i_mid,
  input  logic [ADDRESS_WIDTH-1:0]  i_maddr,
  input  logic [DATA_WIDTH-1:0]     i_mdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mbyte_enable,
  output logic                      o_sresp_valid,
  input  logic                      i_mresp_accept,
  output logic                      o_sresp,
  output logic [ID_WIDTH-1:0]       o_sid,
  output logic                      o_serror,
  output logic [DATA_WIDTH-1:0]     o_sdata,
  output logic [1:0]                o_sresp_last
);

  localparam int BE_WIDTH    = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(BE_WIDTH);
  localparam int INDEX_BITS  = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  regs_q [DEPTH];

  logic                   cmd_take;
  logic                   cmd_np;
  logic                   cmd_read;
  logic                   cmd_write;
  logic                   cmd_full;
  logic                   out_of_range;
  logic [INDEX_BITS-1:0]  index;
  logic                   write_en;
  logic                   unused_addr;

  // Held off during reset so nothing is taken while the block is being cleared.
  assign o_scmd_accept = (state_q == StIdle) && !i_rst;
  assign cmd_take      = i_mcmd_valid && o_scmd_accept;

  // bit3 = non-posted, bit2 = with-data; WRITE family is x10x, bit0 = full write.
  assign cmd_np    = i_mcmd[3];
  assign cmd_read  = (i_mcmd == 4'b1001);
  assign cmd_write = (i_mcmd[2:1] == 2'b10);
  assign cmd_full  = i_mcmd[0];

  assign index        = i_maddr[OFFSET_BITS +: INDEX_BITS];
  assign out_of_range = (i_maddr >> (OFFSET_BITS + INDEX_BITS)) != '0;
  // Byte-offset bits inside a word are deliberately ignored.
  assign unused_addr  = ^i_maddr;

  assign write_en = cmd_take && cmd_write && !out_of_range;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (cmd_full || i_mbyte_enable[b]) begin
          regs_q[index][8*b +: 8] <= i_mdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      o_sresp_valid <= 1'b0;
      o_sresp       <= 1'b0;
      o_sid         <= '0;
      o_serror      <= 1'b0;
      o_sdata       <= '0;
      o_sresp_last  <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Posted commands (bit3 = 0) never produce a response.
          if (cmd_take && cmd_np) begin
            state_q       <= StResp;
            o_sresp_valid <= 1'b1;
            o_sresp       <= cmd_read;
            o_sid         <= i_mid;
            o_sresp_last  <= 2'b11;
            if (cmd_read || cmd_write) begin
              o_serror <= out_of_range;
            end else begin
              o_serror <= 1'b1;
            end
            if (cmd_read && !out_of_range) begin
              o_sdata <= regs_q[index];
            end else begin
              o_sdata <= '0;
            end
          end
        end
        StResp: begin
          if (i_mresp_accept) begin
            state_q       <= StIdle;
            o_sresp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pzcorebus_csr_responder.sv
module tb_pzcorebus_csr_responder;

  logic        clk;
  logic        rst;
  logic        mcmd_valid;
  logic        scmd_accept;
  logic [3:0]  mcmd;
  logic [7:0]  mid;
  logic [31:0] maddr;
  logic [31:0] mdata;
  logic [3:0]  mbyte_enable;
  logic        sresp_valid;
  logic        mresp_accept;
  logic        sresp;
  logic [7:0]  sid;
  logic        serror;
  logic [31:0] sdata;
  logic [1:0]  sresp_last;

  int checks = 0;
  int errors = 0;

  pzcorebus_csr_responder #(
    .ID_WIDTH      (8),
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .DEPTH         (16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mcmd_valid   (mcmd_valid),
    .o_scmd_accept  (scmd_accept),
    .i_mcmd         (mcmd),
    .i_mid          (mid),
    .i_maddr        (maddr),
    .i_mdata        (mdata),
    .i_mbyte_enable (mbyte_enable),
    .o_sresp_valid  (sresp_valid),
    .i_mresp_accept (mresp_accept),
    .o_sresp        (sresp),
    .o_sid          (sid),
    .o_serror       (serror),
    .o_sdata        (sdata),
    .o_sresp_last   (sresp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command from a negedge; it is taken at the following posedge.
  task automatic drive_cmd(input logic [3:0] c, input logic [7:0] id, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    mcmd_valid = 1'b1; mcmd = c; mid = id; maddr = a; mdata = d; mbyte_enable = be;
    @(posedge clk);
    #1;
    mcmd_valid = 1'b0; mcmd = 4'b0000;
  endtask

  task automatic complete_resp();
    @(negedge clk);
    mresp_accept = 1'b1;
    @(posedge clk);
    #1;
    mresp_accept = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (scmd_accept !== 1'b0) begin
      errors++; $display("FAIL reset_accept got %b want 0", scmd_accept);
    end
    checks++;
    if ({sresp_valid, sresp, sid, serror, sdata, sresp_last} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %h %b %h %b want all zero",
               sresp_valid, sresp, sid, serror, sdata, sresp_last);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (scmd_accept !== 1'b1) begin
      errors++; $display("FAIL reset_release_accept got %b want 1", scmd_accept);
    end
  endtask

  task automatic test_write_np();
    drive_cmd(4'b1100, 8'h5A, 32'h8, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, sid, serror, sresp_last, scmd_accept} !== {1'b1, 1'b0, 8'h5A, 1'b0, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL wnp_resp got v=%b r=%b id=%h e=%b last=%b acc=%b want v=1 r=0 id=5a e=0 last=11 acc=0",
               sresp_valid, sresp, sid, serror, sresp_last, scmd_accept);
    end
    checks++;
    if (sdata !== 32'h0) begin
      errors++; $display("FAIL wnp_sdata got %h want 00000000", sdata);
    end
    // Master offers a clobbering full write while the responder is busy.
    mcmd_valid = 1'b1; mcmd = 4'b0101; maddr = 32'h8; mdata = 32'h0; mbyte_enable = 4'hF;
    mid = 8'h33;
    repeat (3) @(posedge clk);
    mdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, sid, serror} !== {1'b1, 1'b0, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL wnp_hold got v=%b r=%b id=%h e=%b want v=1 r=0 id=5a e=0",
               sresp_valid, sresp, sid, serror);
    end
    mcmd_valid = 1'b0; mcmd = 4'b0000;
    complete_resp();
    @(negedge clk);
    checks++;
    if ({sresp_valid, scmd_accept} !== 2'b01) begin
      errors++; $display("FAIL wnp_done got v=%b acc=%b want v=0 acc=1", sresp_valid, scmd_accept);
    end
  endtask

  task automatic test_masked_write();
    drive_cmd(4'b0100, 8'h01, 32'h8, 32'h11223344, 4'b0101);
    @(negedge clk);
    checks++;
    if ({sresp_valid, scmd_accept} !== 2'b01) begin
      errors++; $display("FAIL posted_no_resp got v=%b acc=%b want v=0 acc=1", sresp_valid, scmd_accept);
    end
    drive_cmd(4'b1001, 8'h02, 32'h8, 32'h0, 4'b0000);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, sid, serror, sresp_last} !== {1'b1, 1'b1, 8'h02, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL read_hdr got v=%b r=%b id=%h e=%b last=%b want v=1 r=1 id=02 e=0 last=11",
               sresp_valid, sresp, sid, serror, sresp_last);
    end
    checks++;
    if (sdata !== 32'hDE22BE44) begin
      errors++; $display("FAIL masked_read got %h want de22be44", sdata);
    end
    complete_resp();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mcmd_valid = 1'b1; mcmd = 4'b0100; mid = 8'h10; maddr = 32'h0; mdata = 32'h1;
    mbyte_enable = 4'hF;
    @(posedge clk);
    #1;
    checks++;
    if ({scmd_accept, sresp_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept got acc=%b v=%b want acc=1 v=0", scmd_accept, sresp_valid);
    end
    maddr = 32'h4; mdata = 32'h2;
    @(posedge clk);
    #1;
    mcmd_valid = 1'b0; mcmd = 4'b0000;
    checks++;
    if ({scmd_accept, sresp_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_after got acc=%b v=%b want acc=1 v=0", scmd_accept, sresp_valid);
    end
    drive_cmd(4'b1001, 8'h11, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (sdata !== 32'h1) begin
      errors++; $display("FAIL b2b_read0 got %h want 00000001", sdata);
    end
    complete_resp();
    drive_cmd(4'b1001, 8'h12, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (sdata !== 32'h2) begin
      errors++; $display("FAIL b2b_read4 got %h want 00000002", sdata);
    end
    complete_resp();
  endtask

  task automatic test_errors();
    drive_cmd(4'b1001, 8'h20, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, serror, sdata} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL read_oor got v=%b r=%b e=%b d=%h want v=1 r=1 e=1 d=00000000",
               sresp_valid, sresp, serror, sdata);
    end
    complete_resp();
    drive_cmd(4'b1111, 8'h21, 32'h0, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, sid, serror, sdata} !== {1'b1, 1'b0, 8'h21, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL atomic_np got v=%b r=%b id=%h e=%b d=%h want v=1 r=0 id=21 e=1 d=00000000",
               sresp_valid, sresp, sid, serror, sdata);
    end
    complete_resp();
    // Out-of-range posted write to 0x44 must not alias onto register 1.
    drive_cmd(4'b0101, 8'h22, 32'h44, 32'hFFFFFFFF, 4'hF);
    // Posted atomic is dropped.
    drive_cmd(4'b0111, 8'h23, 32'h0, 32'hFFFFFFFF, 4'hF);
    drive_cmd(4'b1001, 8'h24, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (sdata !== 32'h1) begin
      errors++; $display("FAIL atomic_unchanged got %h want 00000001", sdata);
    end
    complete_resp();
    // Low offset bits ignored: 0x6 is register 1.
    drive_cmd(4'b1001, 8'h25, 32'h6, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({serror, sdata} !== {1'b0, 32'h2}) begin
      errors++; $display("FAIL oor_no_alias got e=%b d=%h want e=0 d=00000002", serror, sdata);
    end
    complete_resp();
  endtask

  task automatic test_full_write();
    drive_cmd(4'b0101, 8'h30, 32'hC, 32'hA5A5A5A5, 4'b0000);
    // Non-posted masked write with no enables leaves the word alone.
    drive_cmd(4'b1100, 8'h31, 32'hC, 32'h0, 4'b0000);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, serror, sdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wnp_be0 got v=%b r=%b e=%b d=%h want v=1 r=0 e=0 d=00000000",
               sresp_valid, sresp, serror, sdata);
    end
    complete_resp();
    drive_cmd(4'b1001, 8'h32, 32'hC, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if (sdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL full_write got %h want a5a5a5a5", sdata);
    end
    complete_resp();
  endtask

  task automatic test_reset_in_resp();
    drive_cmd(4'b1001, 8'h40, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sdata} !== {1'b1, 32'hDE22BE44}) begin
      errors++; $display("FAIL pre_reset_read got v=%b d=%h want v=1 d=de22be44", sresp_valid, sdata);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sresp_valid, scmd_accept} !== 2'b00) begin
      errors++; $display("FAIL async_reset got v=%b acc=%b want v=0 acc=0", sresp_valid, scmd_accept);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({sresp_valid, scmd_accept} !== 2'b01) begin
      errors++; $display("FAIL post_reset got v=%b acc=%b want v=0 acc=1", sresp_valid, scmd_accept);
    end
    drive_cmd(4'b1001, 8'h41, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({sresp_valid, sresp, serror, sdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_cleared got v=%b r=%b e=%b d=%h want v=1 r=1 e=0 d=00000000",
               sresp_valid, sresp, serror, sdata);
    end
    complete_resp();
  endtask

  initial begin
    rst = 1'b1;
    mcmd_valid = 1'b0; mcmd = 4'b0000; mid = '0; maddr = '0; mdata = '0;
    mbyte_enable = '0; mresp_accept = 1'b0;
    test_reset();
    test_write_np();
    test_masked_write();
    test_back_to_back();
    test_errors();
    test_full_write();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
